exu_lsu: RTL and testbench

//  Responder side of the EXU memory-request interface: registers one load/store request
//  per transaction and runs it on the word-addressed data bus (req/gnt, then rvalid).

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/exu_lsu_if.sv | 34 +++
 rtl/lsu_load_align.sv | 40 ++++
 rtl/exu_lsu.sv | 172 +++++++++++++++++
 tb/tb_exu_lsu.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the EXU load/store unit:
//   - lsu_state_e     : transaction FSM states (IDLE / REQ / RSP)
//   - RDTYPE_*        : bit positions inside the 4-bit load-type field
//   - LSU_B/H/W       : access size codes carried in rdtype[1:0]
//   - load_misaligned : alignment rule for loads of a given size
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

    // Load-type field layout: [1:0] size, [2] reserved, [3] unsigned.
    localparam int RDTYPE_SIZE_LO = 0;
    localparam int RDTYPE_SIZE_HI = 1;
    localparam int RDTYPE_RSVD    = 2;
    localparam int RDTYPE_UNS     = 3;

    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;

    // Bytes are always aligned; halfwords need an even address; anything
    // wider (including the unused size code) must be word aligned.
    function automatic logic load_misaligned(input logic [1:0] size,
                                             input logic [1:0] byte_off);
        logic mis;
        case (size)
            LSU_B:   mis = 1'b0;
            LSU_H:   mis = byte_off[0];
            default: mis = (byte_off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exu_lsu_if.sv
// -----------------------------------------------------------------------------
// exu_lsu_if
// Word-addressed data bus between the load/store unit and memory.
//   req    master->slave  request, held until gnt
//   we     master->slave  1 = write
//   addr   master->slave  word address (low two bits zero)
//   be     master->slave  byte enables
//   wdata  master->slave  write data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read data valid
//   rdata  slave->master  read word
// -----------------------------------------------------------------------------
interface exu_lsu_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load data extraction and extension.
//   rdata       in  32  word returned by the bus
//   byte_off    in   2  byte offset of the load address
//   size        in   2  LSU_B / LSU_H / LSU_W
//   is_unsigned in   1  zero-extend instead of sign-extend (B/H only)
//   data        out 32  value to write back
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        byte_sign;
    logic        half_sign;

    // NOTE: every output of a combinational block gets a default on entry so
    // no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        byte_val  = rdata[{byte_off, 3'b000} +: 8];
        half_val  = rdata[{byte_off[1], 4'b0000} +: 16];
        byte_sign = byte_val[7] & ~is_unsigned;
        half_sign = half_val[15] & ~is_unsigned;
        data      = rdata;
        case (size)
            LSU_B:   data = {{24{byte_sign}}, byte_val};
            LSU_H:   data = {{16{half_sign}}, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// -----------------------------------------------------------------------------
// exu_lsu
// Responder side of the EXU memory-request interface. Registers one load or
// store per transaction, runs it on the data bus and writes extended load
// data back to the register file.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_mem_wen/ren       store / load request from the EXU
//   i_mem_addr          byte address
//   i_mem_wdata, i_data_be   lane-aligned store data and byte enables
//   i_mem_rdtype        load type: [1:0] size, [3] unsigned
//   i_rd_wen, i_rd_addr load destination
//   o_busy              stall: request seen this cycle or transaction open
//   bus                 data bus (master side)
//   o_wb_wen/addr/data  register-file write (wen is a one-cycle pulse)
//   o_misalign          one-cycle pulse: misaligned load, no bus access
//   o_bus_err           one-cycle pulse: bus timeout, no writeback
// -----------------------------------------------------------------------------
module exu_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mem_wen,
    input  logic             i_mem_ren,
    input  logic [31:0]      i_mem_addr,
    input  logic [31:0]      i_mem_wdata,
    input  logic [3:0]       i_data_be,
    input  logic [3:0]       i_mem_rdtype,
    input  logic             i_rd_wen,
    input  logic [4:0]       i_rd_addr,
    output logic             o_busy,
    exu_lsu_if.master        bus,
    output logic             o_wb_wen,
    output logic [4:0]       o_wb_addr,
    output logic [31:0]      o_wb_data,
    output logic             o_misalign,
    output logic             o_bus_err
);

    // One spare bit so the timer can never wrap while a transaction is open.
    localparam int unsigned        TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e         state;
    logic [TIMER_W-1:0] timer;

    // Load context kept for extraction and writeback.
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rd_wen_q;
    logic [4:0]  rd_addr_q;

    logic [1:0]  req_size;
    logic [31:0] load_data;
    logic        timed_out;
    logic        unused_rsvd;

    assign req_size    = i_mem_rdtype[RDTYPE_SIZE_HI:RDTYPE_SIZE_LO];
    assign timed_out   = (timer >= TIMER_LAST);
    assign unused_rsvd = i_mem_rdtype[RDTYPE_RSVD];

    // Only combinational output: the EXU must stall in the very cycle it
    // presents a request, before any register can react.
    assign o_busy = ~i_rst & ((state != IDLE) | i_mem_ren | i_mem_wen);

    lsu_load_align u_align (
        .rdata       (bus.rdata),
        .byte_off    (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            timer      <= '0;
            addr_lo_q  <= '0;
            size_q     <= LSU_B;
            uns_q      <= 1'b0;
            rd_wen_q   <= 1'b0;
            rd_addr_q  <= '0;
            bus.req    <= 1'b0;
            bus.we     <= 1'b0;
            bus.addr   <= '0;
            bus.be     <= '0;
            bus.wdata  <= '0;
            o_wb_wen   <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;
        end else begin
            // Pulses default low and are raised for exactly one cycle below.
            o_wb_wen   <= 1'b0;
            o_misalign <= 1'b0;
            o_bus_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_mem_wen) begin
                        // Store has priority; a simultaneous load is dropped.
                        // An all-zero byte mask writes nothing, so skip the bus.
                        if (i_data_be != 4'h0) begin
                            bus.req   <= 1'b1;
                            bus.we    <= 1'b1;
                            bus.addr  <= {i_mem_addr[31:2], 2'b00};
                            bus.be    <= i_data_be;
                            bus.wdata <= i_mem_wdata;
                            timer     <= '0;
                            state     <= REQ;
                        end
                    end else if (i_mem_ren) begin
                        addr_lo_q <= i_mem_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= i_mem_rdtype[RDTYPE_UNS];
                        rd_wen_q  <= i_rd_wen;
                        rd_addr_q <= i_rd_addr;
                        if (load_misaligned(req_size, i_mem_addr[1:0])) begin
                            o_misalign <= 1'b1;
                        end else begin
                            bus.req   <= 1'b1;
                            bus.we    <= 1'b0;
                            bus.addr  <= {i_mem_addr[31:2], 2'b00};
                            bus.be    <= 4'hF;
                            bus.wdata <= '0;
                            timer     <= '0;
                            state     <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (bus.gnt) begin
                        bus.req <= 1'b0;
                        timer   <= timer + 1'b1;
                        state   <= bus.we ? IDLE : RSP;
                    end else if (timed_out) begin
                        bus.req   <= 1'b0;
                        o_bus_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                RSP: begin
                    if (bus.rvalid) begin
                        // Data is presented even when the write is suppressed.
                        o_wb_wen  <= rd_wen_q & (rd_addr_q != 5'd0);
                        o_wb_addr <= rd_addr_q;
                        o_wb_data <= load_data;
                        state     <= IDLE;
                    end else if (timed_out) begin
                        o_bus_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_lsu.sv
// -----------------------------------------------------------------------------
// tb_exu_lsu
// Self-checking bench for exu_lsu. Load expectations are pushed to a
// scoreboard queue when the request is driven and popped by a monitor when
// the DUT pulses o_wb_wen. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_exu_lsu;

    localparam int unsigned TIMEOUT = 64;

    localparam logic [3:0] RT_LB  = 4'b0000;
    localparam logic [3:0] RT_LH  = 4'b0001;
    localparam logic [3:0] RT_LW  = 4'b0010;
    localparam logic [3:0] RT_LBU = 4'b1000;
    localparam logic [3:0] RT_LHU = 4'b1001;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  data_be;
    logic [3:0]  mem_rdtype;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        misalign;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;
    wb_t exp_q[$];

    exu_lsu_if bus ();

    exu_lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mem_wen    (mem_wen),
        .i_mem_ren    (mem_ren),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (mem_wdata),
        .i_data_be    (data_be),
        .i_mem_rdtype (mem_rdtype),
        .i_rd_wen     (rd_wen),
        .i_rd_addr    (rd_addr),
        .o_busy       (busy),
        .bus          (bus),
        .o_wb_wen     (wb_wen),
        .o_wb_addr    (wb_addr),
        .o_wb_data    (wb_data),
        .o_misalign   (misalign),
        .o_bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every writeback pulse must match the oldest entry.
    always @(negedge clk) begin
        if (wb_wen) begin
            wb_t e;
            check("wb_expected", 32'(exp_q.size() > 0), 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("wb_addr", 32'(wb_addr), 32'(e.rd));
            check("wb_data", wb_data, e.data);
        end
    end

    task automatic drive_req(input logic wen, input logic ren, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic [3:0] rdtype, input logic rwen, input logic [4:0] rd);
        mem_wen    = wen;
        mem_ren    = ren;
        mem_addr   = addr;
        mem_wdata  = wdata;
        data_be    = be;
        mem_rdtype = rdtype;
        rd_wen     = rwen;
        rd_addr    = rd;
    endtask

    task automatic idle_req();
        drive_req(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    endtask

    // Load with immediate grant and rvalid one cycle later. With glitch set,
    // a bogus rvalid is driven in the grant cycle and must be ignored.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [3:0] rdtype,
                            input logic rwen, input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input bit glitch);
        if (rwen && rd != 5'd0) exp_q.push_back('{rd: rd, data: exp_data});
        drive_req(1'b0, 1'b1, addr, '0, '0, rdtype, rwen, rd);
        #1 check({tag, "_busy_acc"}, 32'(busy), 1);
        @(negedge clk);
        idle_req();
        #1;
        check({tag, "_req"}, 32'(bus.req), 1);
        check({tag, "_addr"}, bus.addr, {addr[31:2], 2'b00});
        check({tag, "_be_we"}, {27'd0, bus.be, bus.we}, {27'd0, 4'hF, 1'b0});
        bus.gnt = 1'b1;
        if (glitch) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        check({tag, "_req_drop"}, 32'(bus.req), 0);
        check({tag, "_busy_rsp"}, 32'(busy), 1);
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        // Request was cycle 1; writeback pulse is expected in cycle 4.
        check({tag, "_wb_wen_c4"}, 32'(wb_wen), 32'(rwen && rd != 5'd0));
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_busy_idle"}, 32'(busy), 0);
    endtask

    // Store held in REQ for gnt_wait cycles before grant.
    task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input int gnt_wait, input bit also_ren);
        drive_req(1'b1, also_ren, addr, wdata, be, RT_LW, also_ren, 5'd4);
        #1 check({tag, "_busy_acc"}, 32'(busy), 1);
        @(negedge clk);
        idle_req();
        #1;
        if (be == 4'h0) begin
            check({tag, "_nobus_req"}, 32'(bus.req), 0);
            check({tag, "_nobus_busy"}, 32'(busy), 0);
        end else begin
            for (int i = 0; i <= gnt_wait; i++) begin
                check({tag, "_req"}, 32'(bus.req), 1);
                check({tag, "_we"}, 32'(bus.we), 1);
                check({tag, "_addr"}, bus.addr, {addr[31:2], 2'b00});
                check({tag, "_be"}, 32'(bus.be), 32'(be));
                check({tag, "_wdata"}, bus.wdata, wdata);
                check({tag, "_busy"}, 32'(busy), 1);
                if (i == gnt_wait) bus.gnt = 1'b1;
                @(negedge clk);
            end
            bus.gnt = 1'b0;
            #1;
            check({tag, "_req_done"}, 32'(bus.req), 0);
            check({tag, "_busy_done"}, 32'(busy), 0);
        end
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        idle_req();
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(bus.req), 0);
        check("rst_pulses", {29'd0, wb_wen, misalign, bus_err}, 0);
        check("rst_wb_data", wb_data, 0);

        // Loads across sizes, offsets and extension modes (back-to-back).
        run_load("lb",  32'h0000_0103, RT_LB,  1'b1, 5'd5, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0);
        run_load("lhu", 32'h0000_0102, RT_LHU, 1'b1, 5'd6, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1);
        run_load("lh",  32'h0000_0100, RT_LH,  1'b1, 5'd8, 32'h0000_8001, 32'hFFFF_8001, 1'b0);
        run_load("lbu", 32'h0000_0101, RT_LBU, 1'b1, 5'd9, 32'h0000_A500, 32'h0000_00A5, 1'b0);
        run_load("lw0", 32'h0000_0104, RT_LW,  1'b1, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b0);

        // Stores: delayed grant, empty byte mask, store-wins-over-load.
        run_store("sw",   32'h0000_0200, 32'hA5A5_0F0F, 4'hF, 3, 1'b0);
        run_store("sbe0", 32'h0000_0208, 32'h1111_1111, 4'h0, 0, 1'b0);
        run_store("both", 32'h0000_0400, 32'h1122_3344, 4'h3, 0, 1'b1);

        // Misaligned loads: one-cycle pulse, no bus access.
        drive_req(1'b0, 1'b1, 32'h0000_0201, '0, '0, RT_LW, 1'b1, 5'd3);
        @(negedge clk);
        idle_req();
        #1;
        check("mis_w_pulse", 32'(misalign), 1);
        check("mis_w_req", 32'(bus.req), 0);
        check("mis_w_busy", 32'(busy), 0);
        drive_req(1'b0, 1'b1, 32'h0000_0105, '0, '0, RT_LH, 1'b1, 5'd3);
        @(negedge clk);
        idle_req();
        #1;
        check("mis_h_pulse", 32'(misalign), 1);
        check("mis_h_req", 32'(bus.req), 0);
        @(negedge clk);
        check("mis_one_cycle", 32'(misalign), 0);
        check("mis_req_never", 32'(bus.req), 0);

        // Timeout: granted load whose rvalid never comes.
        drive_req(1'b0, 1'b1, 32'h0000_0300, '0, '0, RT_LW, 1'b1, 5'd7);
        @(negedge clk);
        idle_req();
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        waited = 2;
        while (!bus_err && waited < int'(TIMEOUT) + 20) begin
            @(negedge clk);
            waited++;
        end
        check("to_seen", 32'(bus_err), 1);
        check("to_cycles", 32'(waited), TIMEOUT + 1);
        check("to_no_wb", 32'(wb_wen), 0);
        #1 check("to_busy", 32'(busy), 0);
        @(negedge clk);
        check("to_one_cycle", 32'(bus_err), 0);
        run_load("after_to", 32'h0000_0304, RT_LW, 1'b1, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

        // Reset while waiting in RSP, then a stray rvalid.
        drive_req(1'b0, 1'b1, 32'h0000_0500, '0, '0, RT_LW, 1'b1, 5'd9);
        @(negedge clk);
        idle_req();
        bus.gnt = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h55AA_55AA;
        #1;
        check("rr_busy", 32'(busy), 0);
        check("rr_req", 32'(bus.req), 0);
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        check("rr_no_wb", 32'(wb_wen), 0);
        check("rr_wb_data", wb_data, 0);
        check("rr_wb_addr", 32'(wb_addr), 0);
        check("rr_busy_idle", 32'(busy), 0);
        run_load("after_rst", 32'h0000_0502, RT_LH, 1'b1, 5'd10, 32'h7FFF_0000, 32'h0000_7FFF, 1'b0);

        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
